// File: rtl/ecc_pkg.sv
// Shared constants, command encodings and FSM states for the GF(2^233) scalar-multiplication sequencer.
package ecc_pkg;

   localparam int M  = 233;
   localparam int CW = 8;

   localparam logic [CW-1:0] CNT_M    = CW'(M);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   typedef enum logic [1:0] {
      OP_INIT = 2'd0,
      OP_DBL  = 2'd1,
      OP_ADD  = 2'd2,
      OP_RSVD = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SCAN  = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      FIN   = 3'd4
   } state_e;

   // Scalar bits are consumed MSB first.
   function automatic logic [M-1:0] shl1(input logic [M-1:0] v);
      return {v[M-2:0], 1'b0};
   endfunction

endpackage

// File: rtl/ecc_scalar_seq_if.sv
// Command port between the scalar sequencer (master) and the point-arithmetic unit (slave).
interface ecc_scalar_seq_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic       cmd_dummy;
   logic       op_done;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_dummy,
      input  cmd_ready,
      input  op_done
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_dummy,
      output cmd_ready,
      output op_done
   );

endinterface

// File: rtl/ecc_cmd_if.sv
// Command-port register slice: holds valid/op/dummy stable until the point unit takes the command.
module ecc_cmd_if (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [1:0] load_op,
   input  logic       load_dummy,
   input  logic       cmd_ready,
   output logic       cmd_valid,
   output logic [1:0] cmd_op,
   output logic       cmd_dummy,
   output logic       fire
);

   logic       valid_r;
   logic [1:0] op_r;
   logic       dummy_r;

   assign fire      = valid_r & cmd_ready;
   assign cmd_valid = valid_r;
   assign cmd_op    = op_r;
   assign cmd_dummy = dummy_r;

   // Load a new command; op/dummy stay put after the handshake so the FSM can see what just finished.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_r <= 1'b0;
         op_r    <= 2'd0;
         dummy_r <= 1'b0;
      end else if (load) begin
         valid_r <= 1'b1;
         op_r    <= load_op;
         dummy_r <= load_dummy;
      end else if (fire) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

endmodule

// File: rtl/ecc_scalar_seq.sv
// Left-to-right double-and-add sequencer for Q = k*P over GF(2^233).
// Optional constant-time schedule: define ECC_SEQ_CONST_TIME_EN.
module ecc_scalar_seq
   import ecc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [M-1:0]     scalar,
   output logic             busy,
   output logic             done,
   output logic             result_inf,
   ecc_scalar_seq_if.master cmd
);

`ifdef ECC_SEQ_CONST_TIME_EN
   localparam logic CONST_TIME = 1'b1;
`else
   localparam logic CONST_TIME = 1'b0;
`endif

   state_e        state_r, state_s;
   logic [M-1:0]  sreg_r, sreg_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic          bit_cur_r, bit_cur_s;
   logic          zero_r, zero_s;
   logic          busy_r, done_r, inf_r, inf_s;
   logic          load_s, load_dummy_s;
   op_e           load_op_s;
   logic          cmd_valid_s, cmd_dummy_s, fire_s;
   logic [1:0]    cmd_op_s;

   ecc_cmd_if u_cmd (
      .clk        (clk),
      .rst        (rst),
      .load       (load_s),
      .load_op    (load_op_s),
      .load_dummy (load_dummy_s),
      .cmd_ready  (cmd.cmd_ready),
      .cmd_valid  (cmd_valid_s),
      .cmd_op     (cmd_op_s),
      .cmd_dummy  (cmd_dummy_s),
      .fire       (fire_s)
   );

   assign cmd.cmd_valid = cmd_valid_s;
   assign cmd.cmd_op    = cmd_op_s;
   assign cmd.cmd_dummy = cmd_dummy_s;
   assign busy          = busy_r;
   assign done          = done_r;
   assign result_inf    = inf_r;

   // Next-state, scalar scan and command issue decisions.
   always_comb begin
      state_s      = state_r;
      sreg_s       = sreg_r;
      cnt_s        = cnt_r;
      bit_cur_s    = bit_cur_r;
      zero_s       = zero_r;
      inf_s        = 1'b0;
      load_s       = 1'b0;
      load_op_s    = OP_INIT;
      load_dummy_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               sreg_s  = scalar;
               cnt_s   = CNT_M;
               zero_s  = (scalar == {M{1'b0}});
               state_s = SCAN;
            end else begin
               state_s = IDLE;
            end
         end
         SCAN: begin
            // The constant-time schedule never skips leading zeros.
            if (CONST_TIME || sreg_r[M-1]) begin
               sreg_s    = shl1(sreg_r);
               cnt_s     = cnt_r - CNT_ONE;
               load_s    = 1'b1;
               load_op_s = OP_INIT;
               state_s   = ISSUE;
            end else if (cnt_r == CNT_ONE) begin
               inf_s   = 1'b1;
               state_s = FIN;
            end else begin
               sreg_s = shl1(sreg_r);
               cnt_s  = cnt_r - CNT_ONE;
            end
         end
         ISSUE: begin
            if (fire_s) begin
               state_s = WAIT;
            end else begin
               state_s = ISSUE;
            end
         end
         WAIT: begin
            if (cmd.op_done) begin
               if ((cmd_op_s == OP_DBL) && (CONST_TIME || bit_cur_r)) begin
                  load_s       = 1'b1;
                  load_op_s    = OP_ADD;
                  load_dummy_s = CONST_TIME & ~bit_cur_r;
                  state_s      = ISSUE;
               end else if (cnt_r == CNT_ZERO) begin
                  inf_s   = CONST_TIME & zero_r;
                  state_s = FIN;
               end else begin
                  bit_cur_s = sreg_r[M-1];
                  sreg_s    = shl1(sreg_r);
                  cnt_s     = cnt_r - CNT_ONE;
                  load_s    = 1'b1;
                  load_op_s = OP_DBL;
                  state_s   = ISSUE;
               end
            end else begin
               state_s = WAIT;
            end
         end
         FIN: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, scalar registers and registered host outputs; done/result_inf live only in FIN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         sreg_r    <= {M{1'b0}};
         cnt_r     <= CNT_ZERO;
         bit_cur_r <= 1'b0;
         zero_r    <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         inf_r     <= 1'b0;
      end else begin
         state_r   <= state_s;
         sreg_r    <= sreg_s;
         cnt_r     <= cnt_s;
         bit_cur_r <= bit_cur_s;
         zero_r    <= zero_s;
         busy_r    <= (state_s == SCAN) || (state_s == ISSUE) || (state_s == WAIT);
         done_r    <= (state_s == FIN);
         inf_r     <= inf_s;
      end
   end

endmodule
